// File: rtl/ex_pkg.sv
// ex_pkg: shared exception causes, ALU status bit map and EX/MEM FSM states.
package ex_pkg;
  typedef enum logic [2:0] {
    EXC_NONE  = 3'd0,
    EXC_DIVZ  = 3'd1,
    EXC_MOVF  = 3'd2,
    EXC_AOVF  = 3'd3,
    EXC_MISAL = 3'd4
  } exc_cause_e;
  localparam int ST_ZERO  = 7;
  localparam int ST_MOVF  = 6;
  localparam int ST_CARRY = 5;
  localparam int ST_NEG   = 4;
  localparam int ST_MISAL = 3;
  localparam int ST_DIVZ  = 2;
  typedef enum logic {RUN, TRAP} state_e;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: fixed-priority decode of ALU status flags into one exception cause.
module exc_prio_enc
  import ex_pkg::*;
#(
  parameter int STATUS_W = 8
) (
  input  logic [STATUS_W-1:0] status,
  input  logic                ovf_trap_en,
  input  logic                mem_access,
  output exc_cause_e          cause
);
  always_comb
    cause = status[ST_DIVZ]                 ? EXC_DIVZ  :
            status[ST_MOVF]  && ovf_trap_en ? EXC_MOVF  :
            status[ST_CARRY] && ovf_trap_en ? EXC_AOVF  :
            status[ST_MISAL] && mem_access  ? EXC_MISAL : EXC_NONE;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM register slice that squashes faulting entries and
// holds the pipe in TRAP until the exception is acknowledged.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STATUS_W = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [STATUS_W-1:0] alu_status,
  input  logic [DATA_W-1:0]   pc,
  input  logic [4:0]          rd,
  input  logic                reg_write,
  input  logic                mem_access,
  input  logic                ovf_trap_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic                out_zero,
  output logic                out_neg,
  output logic [4:0]          out_rd,
  output logic                out_reg_write,
  output logic                out_mem_access,
  output logic                exc_valid,
  output logic [2:0]          exc_cause,
  output logic [DATA_W-1:0]   exc_pc,
  input  logic                exc_ack,
  output logic [CNT_W-1:0]    exc_count
);
  state_e             state_q, state_d;
  exc_cause_e         cause, exc_cause_q, exc_cause_d;
  logic               out_valid_q, out_valid_d, exc_valid_q, exc_valid_d;
  logic [DATA_W-1:0]  out_result_q, exc_pc_q, exc_pc_d;
  logic [4:0]         out_rd_q;
  logic               out_zero_q, out_neg_q, out_reg_write_q, out_mem_access_q;
  logic [CNT_W-1:0]   exc_count_q, exc_count_d;
  logic               accept, fault, load;
  exc_prio_enc #(.STATUS_W(STATUS_W)) u_enc (
    .status     (alu_status),
    .ovf_trap_en(ovf_trap_en),
    .mem_access (mem_access),
    .cause      (cause)
  );
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign fault    = cause != EXC_NONE;
  assign load     = accept && !fault;
  always_comb begin
    state_d     = state_q;
    exc_valid_d = exc_valid_q;
    exc_cause_d = exc_cause_q;
    exc_pc_d    = exc_pc_q;
    exc_count_d = exc_count_q;
    out_valid_d = flush ? 1'b0 : load ? 1'b1 : out_valid_q && !out_ready;
    if (state_q == TRAP && exc_ack) begin
      state_d     = RUN;
      exc_valid_d = 1'b0;
      exc_cause_d = EXC_NONE;
    end else if (accept && fault) begin
      state_d     = TRAP;
      exc_valid_d = 1'b1;
      exc_cause_d = cause;
      exc_pc_d    = pc;
      exc_count_d = &exc_count_q ? exc_count_q : exc_count_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_zero_q       <= 1'b0;
      out_neg_q        <= 1'b0;
      out_rd_q         <= '0;
      out_reg_write_q  <= 1'b0;
      out_mem_access_q <= 1'b0;
      exc_valid_q      <= 1'b0;
      exc_cause_q      <= EXC_NONE;
      exc_pc_q         <= '0;
      exc_count_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_pc_q    <= exc_pc_d;
      exc_count_q <= exc_count_d;
      if (load) begin
        out_result_q     <= alu_result;
        out_zero_q       <= alu_status[ST_ZERO];
        out_neg_q        <= alu_status[ST_NEG];
        out_rd_q         <= rd;
        out_reg_write_q  <= reg_write;
        out_mem_access_q <= mem_access;
      end
    end
  end
  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_zero       = out_zero_q;
  assign out_neg        = out_neg_q;
  assign out_rd         = out_rd_q;
  assign out_reg_write  = out_reg_write_q;
  assign out_mem_access = out_mem_access_q;
  assign exc_valid      = exc_valid_q;
  assign exc_cause      = exc_cause_q;
  assign exc_pc         = exc_pc_q;
  assign exc_count      = exc_count_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed checks of handshake, exception decode, trap FSM,
// flush and counter saturation (second instance with a 2-bit counter).
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready, exc_ack;
  logic [31:0] alu_result, pc;
  logic [7:0]  alu_status;
  logic [4:0]  rd;
  logic        reg_write, mem_access, ovf_trap_en;
  logic        in_ready, out_valid, out_zero, out_neg, out_reg_write, out_mem_access, exc_valid;
  logic [31:0] out_result, exc_pc;
  logic [4:0]  out_rd;
  logic [2:0]  exc_cause;
  logic [7:0]  exc_count;
  logic        s_in_ready, s_out_valid, s_out_zero, s_out_neg, s_out_reg_write, s_out_mem_access, s_exc_valid;
  logic [31:0] s_out_result, s_exc_pc;
  logic [4:0]  s_out_rd;
  logic [2:0]  s_exc_cause;
  logic [1:0]  s_exc_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_status(alu_status), .pc(pc), .rd(rd),
    .reg_write(reg_write), .mem_access(mem_access), .ovf_trap_en(ovf_trap_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_neg(out_neg), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_access(out_mem_access),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_ack(exc_ack), .exc_count(exc_count)
  );

  ex_mem_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .alu_result(alu_result), .alu_status(alu_status), .pc(pc), .rd(rd),
    .reg_write(reg_write), .mem_access(mem_access), .ovf_trap_en(ovf_trap_en),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
    .out_zero(s_out_zero), .out_neg(s_out_neg), .out_rd(s_out_rd),
    .out_reg_write(s_out_reg_write), .out_mem_access(s_out_mem_access),
    .exc_valid(s_exc_valid), .exc_cause(s_exc_cause), .exc_pc(s_exc_pc),
    .exc_ack(exc_ack), .exc_count(s_exc_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [7:0] st,
                       input logic [31:0] p, input logic [4:0] r, input logic ma);
    in_valid   = v;
    alu_result = res;
    alu_status = st;
    pc         = p;
    rd         = r;
    reg_write  = 1'b1;
    mem_access = ma;
  endtask

  task automatic ack();
    in_valid = 1'b0;
    exc_ack  = 1'b1;
    tick();
    exc_ack  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; exc_ack = 1'b0; ovf_trap_en = 1'b1;
    drive(1'b0, 32'h0, 8'h00, 32'h0, 5'd0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h55, 8'h00, 32'h4, 5'd3, 1'b0);
    tick();
    chk("pre_reset_valid", {31'b0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_rd", {27'b0, out_rd}, 32'h0);
    chk("rst_exc", {28'b0, exc_valid, exc_cause}, 32'h0);
    chk("rst_exc_count", {24'b0, exc_count}, 32'h0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    drive(1'b1, 32'h10, 8'h00, 32'h8, 5'd5, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("basic_valid", {31'b0, out_valid}, 32'h1);
    chk("basic_result", out_result, 32'h10);
    chk("basic_rd", {27'b0, out_rd}, 32'd5);
    chk("basic_rw", {31'b0, out_reg_write}, 32'h1);
    tick();
    chk("basic_drain", {31'b0, out_valid}, 32'h0);

    out_ready = 1'b0;
    drive(1'b1, 32'hA1, 8'h00, 32'hC, 5'd1, 1'b0);
    tick();
    chk("bp_first_valid", {31'b0, out_valid}, 32'h1);
    drive(1'b1, 32'hB2, 8'h00, 32'h10, 5'd2, 1'b0);
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
    tick();
    chk("bp_hold_result", out_result, 32'hA1);
    chk("bp_hold_rd", {27'b0, out_rd}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'b0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_result", out_result, 32'hB2);
    chk("bp_second_rd", {27'b0, out_rd}, 32'd2);
    tick();
    chk("bp_drain", {31'b0, out_valid}, 32'h0);

    drive(1'b1, 32'h0, 8'h84, 32'h40, 5'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("divz_valid", {31'b0, exc_valid}, 32'h1);
    chk("divz_cause", {29'b0, exc_cause}, 32'd1);
    chk("divz_pc", exc_pc, 32'h40);
    chk("divz_squash", {31'b0, out_valid}, 32'h0);
    chk("divz_count", {24'b0, exc_count}, 32'd1);
    chk("sat_count_1", {30'b0, s_exc_count}, 32'd1);
    chk("divz_in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    chk("trap_hold", {31'b0, in_ready}, 32'h0);
    ack();
    chk("ack_valid", {31'b0, exc_valid}, 32'h0);
    chk("ack_cause", {29'b0, exc_cause}, 32'd0);
    chk("ack_pc_kept", exc_pc, 32'h40);
    chk("ack_in_ready", {31'b0, in_ready}, 32'h1);

    drive(1'b1, 32'h0, 8'h64, 32'h44, 5'd6, 1'b0);
    tick();
    chk("prio_64_cause", {29'b0, exc_cause}, 32'd1);
    chk("sat_count_2", {30'b0, s_exc_count}, 32'd2);
    drive(1'b1, 32'h77, 8'h00, 32'h48, 5'd7, 1'b0);
    exc_ack = 1'b1;
    #1;
    chk("ack_trap_in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    exc_ack = 1'b0;
    chk("ack_same_no_accept", {31'b0, out_valid}, 32'h0);
    chk("ack_same_exc_clear", {31'b0, exc_valid}, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("after_ack_accept", {31'b0, out_valid}, 32'h1);
    chk("after_ack_result", out_result, 32'h77);
    tick();

    drive(1'b1, 32'h0, 8'h60, 32'h4C, 5'd8, 1'b0);
    tick();
    chk("prio_60_cause", {29'b0, exc_cause}, 32'd2);
    chk("prio_60_pc", exc_pc, 32'h4C);
    chk("sat_count_3", {30'b0, s_exc_count}, 32'd3);
    ack();
    ovf_trap_en = 1'b0;
    drive(1'b1, 32'h99, 8'h60, 32'h50, 5'd9, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("ovf_dis_no_exc", {31'b0, exc_valid}, 32'h0);
    chk("ovf_dis_pass", {31'b0, out_valid}, 32'h1);
    chk("ovf_dis_result", out_result, 32'h99);
    tick();
    ovf_trap_en = 1'b1;
    drive(1'b1, 32'h0, 8'h20, 32'h54, 5'd9, 1'b0);
    tick();
    chk("aovf_cause", {29'b0, exc_cause}, 32'd3);
    chk("count_4", {24'b0, exc_count}, 32'd4);
    chk("sat_count_4", {30'b0, s_exc_count}, 32'd3);
    ack();

    drive(1'b1, 32'h0, 8'h08, 32'h58, 5'd10, 1'b1);
    tick();
    chk("misal_cause", {29'b0, exc_cause}, 32'd4);
    chk("misal_pc", exc_pc, 32'h58);
    chk("count_5", {24'b0, exc_count}, 32'd5);
    chk("sat_count_5", {30'b0, s_exc_count}, 32'd3);
    ack();
    drive(1'b1, 32'h123, 8'h08, 32'h5C, 5'd11, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("misal_nomem_exc", {31'b0, exc_valid}, 32'h0);
    chk("misal_nomem_pass", out_result, 32'h123);
    chk("misal_nomem_ma", {31'b0, out_mem_access}, 32'h0);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_held", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b1;
    drive(1'b1, 32'h5A, 8'h00, 32'h60, 5'd12, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_beats_load", {31'b0, out_valid}, 32'h0);
    chk("flush_count_kept", {24'b0, exc_count}, 32'd5);

    drive(1'b1, 32'h0, 8'h90, 32'h64, 5'd13, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("flags_zero_neg", {30'b0, out_zero, out_neg}, 32'h3);
    tick();

    drive(1'b1, 32'h0, 8'h04, 32'h68, 5'd14, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_trap", {31'b0, exc_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_trap_exc", {28'b0, exc_valid, exc_cause}, 32'h0);
    chk("rst_trap_count", {24'b0, exc_count}, 32'h0);
    chk("rst_trap_pc", exc_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    chk("rst_trap_in_ready", {31'b0, in_ready}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
EX→MEM pipeline stage placed directly downstream of the ALU. It registers the ALU result and status byte with a valid/ready handshake. It also decodes the status flags into a prioritized exception, squashes the faulting instruction, and holds the pipeline in a trap state until the exception is acknowledged. A saturating counter records how many exceptions have been taken.

Parameters:
DATA_W, 32, width of result and PC
STATUS_W, 8, width of ALU status byte (bit map fixed below)
CNT_W, 8, width of saturating exception counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of held output entry
in_valid  in  1  EX entry valid
in_ready  out  1  stage can accept EX entry
alu_result  in  DATA_W  ALU result
alu_status  in  STATUS_W  [7]=zero [6]=mul overflow [5]=add/sub carry [4]=negative [3]=misaligned (load/store address op) [2]=div by zero [1:0]=0
pc  in  DATA_W  PC of EX instruction
rd  in  5  destination register
reg_write  in  1  instruction writes rd
mem_access  in  1  instruction is load/store
ovf_trap_en  in  1  enables overflow traps (status bits 6, 5)
out_valid  out  1  MEM entry valid
out_ready  in  1  MEM consumes entry
out_result  out  DATA_W  registered result
out_zero  out  1  registered status[7]
out_neg  out  1  registered status[4]
out_rd  out  5  registered rd
out_reg_write  out  1  registered reg_write
out_mem_access  out  1  registered mem_access
exc_valid  out  1  exception pending
exc_cause  out  3  0 none, 1 DIVZ, 2 MOVF, 3 AOVF, 4 MISAL
exc_pc  out  DATA_W  PC of faulting instruction
exc_ack  in  1  handler acknowledges exception
exc_count  out  CNT_W  saturating count of exceptions taken

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; FSM goes to RUN.
  - Reset mid-trap or mid-transfer discards everything.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready). It is combinational and does not depend on in_valid.
  - An entry is accepted when in_valid && in_ready.
  - Output contents are held stable while out_valid && !out_ready.
  - Latency is 1 cycle: an entry accepted at edge N appears with out_valid=1 after edge N.
- Exception decode (combinational on inputs), fixed priority:
  - DIVZ if status[2]
  - else MOVF if status[6] && ovf_trap_en
  - else AOVF if status[5] && ovf_trap_en
  - else MISAL if status[3] && mem_access
- Accepted entry with no exception: load out_* registers and set out_valid=1.
- Accepted entry with an exception:
  - The entry is squashed: out_valid is not set and no out_* field is loaded.
  - If out_valid was 1 and out_ready=1 in that cycle, out_valid clears as usual.
  - exc_cause and exc_pc are loaded, exc_valid=1, exc_count increments (saturates at all-ones), FSM goes to TRAP.
- FSM:
  - RUN → TRAP on an accepted faulting entry.
  - TRAP → RUN on exc_ack: exc_valid=0 and exc_cause=0 in the same edge; exc_pc keeps its value.
  - exc_ack in RUN is ignored.
  - In TRAP, in_ready=0, but a held out_valid entry can still drain via out_ready.
- flush:
  - Clears out_valid at the next edge, overriding both out_ready and a same-cycle load (flush wins).
  - Does not affect the FSM, exc_* or exc_count.
  - in_ready is unaffected by flush.
- Simultaneous exc_ack and in_valid in TRAP: no accept that cycle. The entry can be accepted in the following RUN cycle.
- Width rules: no arithmetic except the counter, which is CNT_W-bit saturating with no wrap.

Decomposition:
- Shared package ex_pkg holds:
  - exc_cause_e: EXC_NONE=0, EXC_DIVZ=1, EXC_MOVF=2, EXC_AOVF=3, EXC_MISAL=4
  - Status bit index constants: ST_ZERO=7, ST_MOVF=6, ST_CARRY=5, ST_NEG=4, ST_MISAL=3, ST_DIVZ=2
  - FSM type: RUN, TRAP
- One sub-module, exc_prio_enc: purely combinational status + enables → exc_cause_e. It is reused by the decode stage later.

Test Plan:
- Reset with rst_n=0 mid-stream → all outputs 0, in_ready=1 after release. Then result=0x00000010, status=0x00, rd=5 → out_valid=1 next cycle, out_result=0x10, out_rd=5.
- Backpressure: out_ready=0 while two entries are offered → first entry is held stable, in_ready=0. Second entry is accepted only in the cycle out_ready=1.
- status=0x84 (div-by-zero, zero), pc=0x40 → exc_valid=1, exc_cause=1, exc_pc=0x40, out_valid stays 0, exc_count=1, in_ready=0 until exc_ack. After ack: exc_cause=0, in_ready=1.
- Priority: status=0x64 with ovf_trap_en=1 → cause 1. status=0x60 with ovf_trap_en=1 → cause 2. status=0x60 with ovf_trap_en=0 → no exception and the entry passes through.
- status=0x08 with mem_access=1 → cause 4. Same status with mem_access=0 → normal pass-through. Separately, flush with out_valid=1 and out_ready=0 → out_valid=0 next cycle.
- With CNT_W=2, five faulting entries each acknowledged → exc_count reads 1, 2, 3, 3, 3.
